muldiv_unit: RTL

// - Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the MIPS pipeline.
// - Signed and unsigned operations; multiply and divide latencies are configurable.
// - Drives busy so hazard logic can stall MFHI/MFLO and any new muldiv op.
// - Instruction decode lives outside this block; it sees only an op code and its operands.

---
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Handshake/data bundle between the EX stage and the multiply/divide unit.
//   start  : op valid this cycle (EX stage -> unit)
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//   a, b   : rs / rt operands, already forwarded
//   busy   : operation in flight, HI/LO not yet valid (unit -> EX stage)
//   hi, lo : architectural HI/LO registers (unit -> EX stage)
// modport master : the pipeline side driving ops
// modport slave  : the muldiv unit
// ---------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS EX stage.
// The result is computed at accept time into a pending register; busy is held
// for a fixed latency and HI/LO are updated from the pending register when
// the latency expires, so HI/LO stay stable while busy.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : muldiv_if.slave (start/op/a/b in, busy/hi/lo out)
//
// Parameters:
//   WIDTH       : operand width, HI and LO are WIDTH bits each
//   MULT_CYCLES : busy cycles for MULT/MULTU/MADD/MSUB (>=1)
//   DIV_CYCLES  : busy cycles for DIV/DIVU (>=1)
//
// Build option:
//   MULDIV_MADD_EN : when defined, op 6 is MADD ({hi,lo} += a*b signed) and
//                    op 7 is MSUB ({hi,lo} -= a*b signed). When undefined,
//                    ops 6/7 are no-ops.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_reg;
  logic                 busy_reg;
  logic [CW-1:0]        cnt_reg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic [2*WIDTH-1:0]   pend_reg;

  // ---------------- multiplier ----------------
  // Sign-extending to 2*WIDTH and keeping the low 2*WIDTH bits of the product
  // yields the exact signed product without a separate signed multiplier.
  logic [2*WIDTH-1:0]   a_sx;
  logic [2*WIDTH-1:0]   b_sx;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   prod_u;

  assign a_sx   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign b_sx   = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // ---------------- divider ----------------
  // One unsigned divider serves both DIV and DIVU: signed operands are
  // reduced to magnitudes and the signs are reapplied afterwards. The
  // overflow case (-2^(W-1) / -1) falls out naturally as -2^(W-1), rem 0.
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic             div_by_zero;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] uquo;
  logic [WIDTH-1:0] urem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign div_signed  = (bus.op == OP_DIV);
  assign a_neg       = div_signed & bus.a[WIDTH-1];
  assign b_neg       = div_signed & bus.b[WIDTH-1];
  assign div_by_zero = (bus.b == '0);
  assign div_n       = a_neg ? -bus.a : bus.a;
  // Divisor forced to 1 on divide-by-zero so the divider never sees 0; the
  // result is replaced by the fixed divide-by-zero pattern anyway.
  assign div_d       = div_by_zero ? WIDTH'(1) : (b_neg ? -bus.b : bus.b);
  assign uquo        = div_n / div_d;
  assign urem        = div_n % div_d;
  assign quo         = (a_neg ^ b_neg) ? -uquo : uquo;
  assign rem         = a_neg ? -urem : urem;

  // ---------------- op decode ----------------
  logic               launch;
  logic [CW-1:0]      lat;
  logic [2*WIDTH-1:0] res;

  always_comb begin
    launch = 1'b0;
    lat    = MULT_LAT;
    res    = prod_s;
    case (bus.op)
      OP_MULT: begin
        launch = 1'b1;
        res    = prod_s;
      end
      OP_MULTU: begin
        launch = 1'b1;
        res    = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        launch = 1'b1;
        lat    = DIV_LAT;
        res    = div_by_zero ? {bus.a, {WIDTH{1'b1}}} : {rem, quo};
      end
`ifdef MULDIV_MADD_EN
      // Accumulate uses HI/LO as they stand at accept time.
      OP_MADD: begin
        launch = 1'b1;
        res    = {hi_reg, lo_reg} + prod_s;
      end
      OP_MSUB: begin
        launch = 1'b1;
        res    = {hi_reg, lo_reg} - prod_s;
      end
`endif
      default: begin
        launch = 1'b0;
      end
    endcase
  end

  // ---------------- control FSM + HI/LO ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      pend_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MTHI) begin
              hi_reg <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              lo_reg <= bus.a;
            end else if (launch) begin
              pend_reg  <= res;
              cnt_reg   <= lat;
              busy_reg  <= 1'b1;
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          // start is ignored here; hazard logic stalls the pipeline instead.
          if (cnt_reg == CNT_ONE) begin
            hi_reg    <= pend_reg[2*WIDTH-1:WIDTH];
            lo_reg    <= pend_reg[WIDTH-1:0];
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule
